// File: rtl/i2s_mic_capture_ctrl.sv
// I2S master for a MEMS microphone. It generates SCK/WS, deserializes 24-bit samples and queues them for Avalon reads.
// Defining I2S_MIC_IRQ_EN builds the THRESH register and the level interrupt. Without it, irq is tied to 0.
module i2s_mic_capture_ctrl #(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        audio_sck,
  output logic        audio_ws,
  input  logic        audio_sd
);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic             ctrl_en, irq_en, ovf;
  logic [1:0]       chsel;
  logic [15:0]      thresh;
  logic [DIV_W-1:0] div;
  logic [5:0]       bit_cnt;
  logic [23:0]      shift;
  logic             push_pend, push_ch;
  logic [24:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             active, tick, rise, fall, capture_slot;
  logic             wr_sel, rd_sel, flush, do_pop, push_req, do_push, ovf_set;
  logic             full, empty, ch_ok;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The serial engine only advances while RUN and EN are both set, so clearing EN stops SCK on the next edge.
  always_comb begin
    state_next = state;
    active     = 1'b0;
    case (state)
      IDLE: if (ctrl_en) state_next = RUN;
      RUN: begin
        active = ctrl_en;
        if (!ctrl_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tick         = active && (div == DIV_W'(CLK_DIV - 1));
  assign rise         = tick && !audio_sck;
  assign fall         = tick && audio_sck;
  assign capture_slot = (bit_cnt[4:0] >= 5'd1) && (bit_cnt[4:0] <= 5'd24);
  assign audio_ws     = bit_cnt[5];

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      div       <= '0;
      audio_sck <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (tick) audio_sck <= !audio_sck;
      if (fall) bit_cnt <= bit_cnt + 6'd1;
      if (rise && capture_slot) shift <= {shift[22:0], audio_sd};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_pend <= 1'b0;
      push_ch   <= 1'b0;
    end else begin
      push_pend <= rise && (bit_cnt[4:0] == 5'd24);
      if (rise && (bit_cnt[4:0] == 5'd24)) push_ch <= bit_cnt[5];
    end
  end

  always_comb begin
    ch_ok = 1'b1;
    case (chsel)
      2'b01:   ch_ok = !push_ch;
      2'b10:   ch_ok = push_ch;
      default: ch_ok = 1'b1;
    endcase
  end

  assign wr_sel   = chipselect && write;
  assign rd_sel   = chipselect && read;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign flush    = wr_sel && (address == 2'd0) && writedata[4];
  assign do_pop   = rd_sel && (address == 2'd2) && !empty;
  assign push_req = push_pend && ch_ok && !flush;
  // When full, a push still fits if a pop frees a slot on the same edge.
  assign do_push  = push_req && (!full || do_pop);
  assign ovf_set  = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_ch, shift};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = {28'b0, irq_en, chsel, ctrl_en};
      2'd1:    rd_mux = {14'b0, empty, ovf, 16'(count)};
      2'd2:    rd_mux = empty ? 32'd0 : {7'b0, mem[rd_ptr]};
      default: rd_mux = {16'b0, thresh};
    endcase
  end

  // A same-cycle overflow event beats the write-1-to-clear of the sticky bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en  <= 1'b0;
      chsel    <= 2'b00;
      ovf      <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_sel && (address == 2'd0)) begin
        ctrl_en <= writedata[0];
        chsel   <= writedata[2:1];
      end
      if (ovf_set) ovf <= 1'b1;
      else if (wr_sel && (address == 2'd1) && writedata[16]) ovf <= 1'b0;
      if (rd_sel) readdata <= rd_mux;
    end
  end

`ifdef I2S_MIC_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      thresh <= 16'd8;
      irq    <= 1'b0;
    end else begin
      if (wr_sel && (address == 2'd0)) irq_en <= writedata[3];
      if (wr_sel && (address == 2'd3)) thresh <= writedata[15:0];
      irq <= irq_en && (16'(count) >= thresh) && (thresh != 16'd0);
    end
  end
`else
  assign irq_en = 1'b0;
  assign thresh = 16'd0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_mic_capture_ctrl.sv
// Bench for i2s_mic_capture_ctrl. A behavioural microphone plays random frames, and an expected-word queue scores the FIFO contents.
// Reset, capture, channel select, overflow, disable, flush, irq and mid-frame reset each have a scenario task.
module tb_i2s_mic_capture_ctrl;
  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FRAME      = 128 * CLK_DIV;
  localparam int HALF_FRAME = 64 * CLK_DIV;
  // Push edges counted from the enabling write edge: one clk to enter RUN, then SCK rise 25 (left) or 57 (right), then one clk.
  localparam int L_PUSH     = 1 + (2 * 25 - 1) * CLK_DIV + 1;
  localparam int R_PUSH     = 1 + (2 * 57 - 1) * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq, audio_sck, audio_ws;
  logic        audio_sd = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [23:0] l_samp [16];
  logic [23:0] r_samp [16];
  logic        mic_on = 1'b0;
  int          mic_gen = 0;
  int          mic_seen = 0;
  int          mic_n = 0;
  int          mic_slot, mic_s, mic_f, mic_idx;

  i2s_mic_capture_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
    .audio_sck(audio_sck), .audio_ws(audio_ws), .audio_sd(audio_sd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Microphone: after SCK fall n, the slot is n mod 64; slots 1..24 of each half carry MSB-first data.
  always @(negedge audio_sck) begin
    if (mic_on) begin
      if (mic_seen != mic_gen) begin
        mic_seen = mic_gen;
        mic_n = 0;
      end
      mic_n++;
      mic_slot = mic_n % 64;
      mic_s    = mic_slot % 32;
      mic_f    = (mic_n / 64) % 16;
      mic_idx  = 24 - mic_s;
      if (mic_s >= 1 && mic_s <= 24)
        audio_sd = (mic_slot >= 32) ? r_samp[mic_f][mic_idx] : l_samp[mic_f][mic_idx];
      else
        audio_sd = 1'b0;
    end
  end

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target - 1) @(negedge clk);
  endtask

  task automatic new_samples();
    for (int i = 0; i < 16; i++) begin
      l_samp[i] = 24'($urandom);
      r_samp[i] = 24'($urandom);
    end
  endtask

  task automatic mic_start();
    mic_gen = mic_gen + 1;
    mic_on = 1'b1;
  endtask

  task automatic mic_stop();
    mic_on = 1'b0;
  endtask

  task automatic expect_frames(input int f0, input int nf, input logic [1:0] cs);
    for (int f = f0; f < f0 + nf; f++) begin
      if (cs != 2'b10) exp_q.push_back({8'h00, l_samp[f]});
      if (cs != 2'b01) exp_q.push_back({8'h01, r_samp[f]});
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int bad;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got rd=%h irq=%b exp rd=0 irq=0", readdata, irq);
    end
    av_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
    av_read(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL reset_status got %h exp 00020000", d); end
    av_read(2'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", d); end
    av_read(2'd3, d);
`ifdef I2S_MIC_IRQ_EN
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL reset_thresh got %h exp 8", d); end
`else
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_thresh got %h exp 0", d); end
`endif
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (audio_sck !== 1'b0 || audio_ws !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_pins got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_capture();
    logic [31:0] d, e;
    int w, first_sck, last_t, n_ws;
    logic prev_ws;
    new_samples();
    l_samp[0] = 24'hABCDEF;
    r_samp[0] = 24'h123456;
    mic_start();
    av_write(2'd0, 32'h1);
    w = cyc; first_sck = 0; last_t = w + 1; n_ws = 0; prev_ws = 1'b0;
    while (cyc < w + 2 * FRAME + 100) begin
      @(negedge clk);
      if (first_sck == 0 && audio_sck === 1'b1) first_sck = cyc - w;
      if (audio_ws !== prev_ws) begin
        n_ws++;
        checks++;
        if (cyc - last_t != HALF_FRAME) begin
          errors++; $display("FAIL ws_period got %0d exp %0d", cyc - last_t, HALF_FRAME);
        end
        last_t = cyc; prev_ws = audio_ws;
      end
    end
    checks++; if (first_sck != CLK_DIV + 1) begin errors++; $display("FAIL sck_start got %0d exp %0d", first_sck, CLK_DIV + 1); end
    checks++; if (n_ws != 4) begin errors++; $display("FAIL ws_toggles got %0d exp 4", n_ws); end
    mic_stop();
    av_write(2'd0, 32'h0);
    expect_frames(0, 2, 2'b00);
    av_read(2'd1, d);
    checks++; if (d[15:0] !== 16'(exp_q.size())) begin errors++; $display("FAIL cap_count got %0d exp %0d", d[15:0], exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      av_read(2'd2, d);
      checks++; if (d !== e) begin errors++; $display("FAIL cap_data got %h exp %h", d, e); end
    end
    av_read(2'd2, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL empty_read got %h exp 0", d); end
    av_read(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL cap_status got %h exp 00020000", d); end
  endtask

  task automatic test_chsel();
    logic [31:0] d, e;
    logic [1:0] cs_tab [3] = '{2'b10, 2'b01, 2'b11};
    int nf_tab [3] = '{4, 2, 1};
    int w;
    for (int k = 0; k < 3; k++) begin
      new_samples();
      mic_start();
      av_write(2'd0, {29'd0, cs_tab[k], 1'b1});
      w = cyc;
      wait_until(w + nf_tab[k] * FRAME + 50);
      av_write(2'd0, 32'h0);
      mic_stop();
      expect_frames(0, nf_tab[k], cs_tab[k]);
      av_read(2'd1, d);
      checks++; if (d[15:0] !== 16'(exp_q.size())) begin errors++; $display("FAIL chsel_count cs=%b got %0d exp %0d", cs_tab[k], d[15:0], exp_q.size()); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        av_read(2'd2, d);
        checks++; if (d !== e) begin errors++; $display("FAIL chsel_data cs=%b got %h exp %h", cs_tab[k], d, e); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    int w;
    new_samples();
    mic_start();
    av_write(2'd0, 32'h1);
    w = cyc;
    wait_until(w + 9 * FRAME + 10);
    expect_frames(0, 8, 2'b00);
    av_read(2'd1, d);
    checks++; if (d !== 32'h0001_0010) begin errors++; $display("FAIL ovf_status got %h exp 00010010", d); end
    av_write(2'd1, 32'h0001_0000);
    av_read(2'd1, d);
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL ovf_clear got %h exp 00000010", d); end
    // Pop lands on the same edge as the frame-9 left push.
    wait_until(w + 9 * FRAME + L_PUSH);
    av_read(2'd2, d);
    e = exp_q.pop_front();
    exp_q.push_back({8'h00, l_samp[9]});
    checks++; if (d !== e) begin errors++; $display("FAIL full_pop got %h exp %h", d, e); end
    av_write(2'd0, 32'h0);
    mic_stop();
    av_read(2'd1, d);
    checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL full_pushpop got %h exp 00000010", d); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      av_read(2'd2, d);
      checks++; if (d !== e) begin errors++; $display("FAIL ovf_data got %h exp %h", d, e); end
    end
  endtask

  task automatic test_disable_mid();
    logic [31:0] d, e;
    int w;
    new_samples();
    mic_start();
    av_write(2'd0, 32'h1);
    w = cyc;
    wait_until(w + 205);
    av_write(2'd0, 32'h0);
    mic_stop();
    @(negedge clk);
    checks++; if (audio_sck !== 1'b0 || audio_ws !== 1'b0) begin errors++; $display("FAIL dis_pins got sck=%b ws=%b exp 0 0", audio_sck, audio_ws); end
    repeat (1000) @(negedge clk);
    av_read(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL dis_nopush got %h exp 00020000", d); end
    new_samples();
    mic_start();
    av_write(2'd0, 32'h1);
    w = cyc;
    wait_until(w + FRAME + 50);
    av_write(2'd0, 32'h0);
    mic_stop();
    expect_frames(0, 1, 2'b00);
    av_read(2'd1, d);
    checks++; if (d[15:0] !== 16'd2) begin errors++; $display("FAIL reen_count got %0d exp 2", d[15:0]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      av_read(2'd2, d);
      checks++; if (d !== e) begin errors++; $display("FAIL reen_data got %h exp %h", d, e); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int w;
    new_samples();
    mic_start();
    av_write(2'd0, 32'h1);
    w = cyc;
    wait_until(w + L_PUSH);
    av_write(2'd0, 32'h11);
    av_read(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL flush_push got %h exp 00020000", d); end
    wait_until(w + R_PUSH + 5);
    av_read(2'd1, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL flush_after got %h exp 00000001", d); end
    av_read(2'd0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL flush_ctrl got %h exp 1", d); end
    av_write(2'd0, 32'h10);
    mic_stop();
    av_read(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL flush_empty got %h exp 00020000", d); end
  endtask

`ifdef I2S_MIC_IRQ_EN
  task automatic test_irq();
    logic [31:0] d, e;
    int w;
    av_write(2'd3, 32'd3);
    av_read(2'd3, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL thresh_rw got %h exp 3", d); end
    new_samples();
    mic_start();
    av_write(2'd0, 32'h9);
    w = cyc;
    wait_until(w + FRAME + L_PUSH + 1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    av_write(2'd0, 32'h8);
    mic_stop();
    expect_frames(0, 1, 2'b00);
    exp_q.push_back({8'h00, l_samp[1]});
    e = exp_q.pop_front();
    av_read(2'd2, d);
    checks++; if (d !== e) begin errors++; $display("FAIL irq_pop got %h exp %h", d, e); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
    av_write(2'd3, 32'd2);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_thresh2 got %b exp 1", irq); end
    av_write(2'd3, 32'd0);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_thresh0 got %b exp 0", irq); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      av_read(2'd2, d);
      checks++; if (d !== e) begin errors++; $display("FAIL irq_data got %h exp %h", d, e); end
    end
    av_write(2'd0, 32'h0);
  endtask
`else
  task automatic test_irq_off();
    logic [31:0] d;
    int w, high;
    av_write(2'd3, 32'd3);
    av_read(2'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL thresh_absent got %h exp 0", d); end
    new_samples();
    mic_start();
    av_write(2'd0, 32'h9);
    av_read(2'd0, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_irqen_absent got %h exp 1", d); end
    w = cyc; high = 0;
    while (cyc < w + FRAME + L_PUSH + 20) begin
      @(negedge clk);
      if (irq !== 1'b0) high++;
    end
    checks++; if (high != 0) begin errors++; $display("FAIL irq_off got %0d high cycles exp 0", high); end
    av_write(2'd0, 32'h10);
    mic_stop();
    av_read(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL irq_off_flush got %h exp 00020000", d); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    int w;
    new_samples();
    mic_start();
    av_write(2'd0, 32'h1);
    w = cyc;
    wait_until(w + 300);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mic_stop();
    checks++; if (audio_sck !== 1'b0 || audio_ws !== 1'b0 || readdata !== 32'd0) begin
      errors++; $display("FAIL rst_mid_pins got sck=%b ws=%b rd=%h exp 0 0 0", audio_sck, audio_ws, readdata);
    end
    wait_until(w + 500);
    av_read(2'd1, d);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL rst_mid_status got %h exp 00020000", d); end
    av_read(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_mid_ctrl got %h exp 0", d); end
`ifdef I2S_MIC_IRQ_EN
    av_read(2'd3, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL rst_mid_thresh got %h exp 8", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_capture();
    test_chsel();
    test_overflow();
    test_disable_mid();
    test_flush();
`ifdef I2S_MIC_IRQ_EN
    test_irq();
`else
    test_irq_off();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
